// File: rtl/pdp8_pkg.sv
// Shared PDP-8 types: decoder opcode structs, execute-stage state and ALU encodings.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 12
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 12
`endif

package pdp8_pkg;

   localparam logic [`ADDR_WIDTH-1:0] START_ADDR = 12'o200;

   typedef struct packed {
      logic                   op_and;
      logic                   op_tad;
      logic                   op_isz;
      logic                   op_dca;
      logic                   op_jms;
      logic                   op_jmp;
      logic [`ADDR_WIDTH-1:0] mem_inst_addr;
   } pdp_mem_opcode_s;

   typedef struct packed {
      logic nop;
      logic cla;
      logic cll;
      logic cma;
      logic cml;
      logic iac;
      logic hlt;
   } pdp_op7_opcode_s;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      RD   = 3'd1,
      WR   = 3'd2,
      DONE = 3'd3,
      HALT = 3'd4
   } exec_state_e;

   typedef enum logic [1:0] {
      ALU_AND = 2'd0,
      ALU_TAD = 2'd1,
      ALU_INC = 2'd2,
      ALU_OP7 = 2'd3
   } alu_op_e;

   typedef struct packed {
      logic cla;
      logic cll;
      logic cma;
      logic cml;
      logic iac;
   } alu_op7_s;

endpackage

// File: rtl/exec_alu.sv
// Combinational datapath of the execute stage: AND/TAD with a memory operand,
// the ISZ increment, and the op7 group-1 subset applied in CLA/CLL, CMA/CML, IAC order.
module exec_alu
   import pdp8_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = `DATA_WIDTH
) (
   input  logic [DATA_WIDTH-1:0] ac,
   input  logic                  link,
   input  logic [DATA_WIDTH-1:0] operand,
   input  alu_op_e               op,
   input  alu_op7_s              op7,
   output logic [DATA_WIDTH-1:0] new_ac,
   output logic                  new_link,
   output logic                  zero
);

   localparam logic [DATA_WIDTH:0] ONE = {{DATA_WIDTH{1'b0}}, 1'b1};

   logic [DATA_WIDTH:0]   sum;
   logic [DATA_WIDTH-1:0] acc;
   logic                  lnk;

   always_comb begin
      sum = '0;
      acc = ac;
      lnk = link;
      case (op)
         ALU_AND: acc = ac & operand;
         ALU_TAD: begin
            sum = {1'b0, ac} + {1'b0, operand};
            acc = sum[DATA_WIDTH-1:0];
            lnk = link ^ sum[DATA_WIDTH];
         end
         ALU_INC: begin
            sum = {1'b0, operand} + ONE;
            acc = sum[DATA_WIDTH-1:0];
         end
         default: begin
            if (op7.cla) acc = '0;
            if (op7.cll) lnk = 1'b0;
            if (op7.cma) acc = ~acc;
            if (op7.cml) lnk = ~lnk;
            if (op7.iac) begin
               sum = {1'b0, acc} + ONE;
               acc = sum[DATA_WIDTH-1:0];
               lnk = lnk ^ sum[DATA_WIDTH];
            end
         end
      endcase
      new_ac   = acc;
      new_link = lnk;
      zero     = (acc == '0);
   end

endmodule

// File: rtl/exec_memref_unit.sv
// PDP-8 execute stage: runs memory-reference and op7 instructions from instr_decode
// over a req/ack memory port, owning AC, Link and PC.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 12
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 12
`endif

module exec_memref_unit
   import pdp8_pkg::*;
#(
   parameter int unsigned           ADDR_WIDTH = `ADDR_WIDTH,
   parameter int unsigned           DATA_WIDTH = `DATA_WIDTH,
   parameter logic [ADDR_WIDTH-1:0] START_ADDR = pdp8_pkg::START_ADDR
) (
   input  logic                  clk,
   input  logic                  reset,
   input  pdp_mem_opcode_s       pdp_mem_opcode,
   input  pdp_op7_opcode_s       pdp_op7_opcode,
   output logic                  stall,
   output logic [ADDR_WIDTH-1:0] PC_value,
   output logic                  mem_rd_req,
   output logic                  mem_wr_req,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wr_data,
   input  logic [DATA_WIDTH-1:0] mem_rd_data,
   input  logic                  mem_ack,
   output logic [DATA_WIDTH-1:0] ac_out,
   output logic                  link_out,
   output logic                  halted
);

   exec_state_e           state;
   logic [ADDR_WIDTH-1:0] pc;
   logic [ADDR_WIDTH-1:0] pc_inc;
   logic [DATA_WIDTH-1:0] ac;
   logic [DATA_WIDTH-1:0] rd_q;
   logic                  link;
   logic                  skip;
   logic                  op7_sel;
   pdp_mem_opcode_s       mem_q;
   alu_op7_s              op7_q;

   logic                  mem_any;
   logic                  op7_any;
   logic                  accept;
   alu_op_e               alu_op;
   logic [DATA_WIDTH-1:0] alu_operand;
   logic [DATA_WIDTH-1:0] alu_ac;
   logic                  alu_link;
   logic                  alu_zero;

   assign mem_any = |{pdp_mem_opcode.op_and, pdp_mem_opcode.op_tad, pdp_mem_opcode.op_isz,
                      pdp_mem_opcode.op_dca, pdp_mem_opcode.op_jms, pdp_mem_opcode.op_jmp};
   assign op7_any = |{pdp_op7_opcode.nop, pdp_op7_opcode.cla, pdp_op7_opcode.cll,
                      pdp_op7_opcode.cma, pdp_op7_opcode.cml, pdp_op7_opcode.iac,
                      pdp_op7_opcode.hlt};
   assign accept  = (state == IDLE) && !stall && (mem_any || op7_any);
   assign pc_inc  = pc + ADDR_WIDTH'(1);

   assign PC_value = pc;
   assign ac_out   = ac;
   assign link_out = link;

   // In RD the ALU increments the live read data for ISZ; otherwise it works on the latched operand.
   always_comb begin
      alu_op      = ALU_OP7;
      alu_operand = rd_q;
      if (state == RD) begin
         alu_op      = ALU_INC;
         alu_operand = mem_rd_data;
      end else if (mem_q.op_and) begin
         alu_op = ALU_AND;
      end else if (mem_q.op_tad) begin
         alu_op = ALU_TAD;
      end
   end

   exec_alu #(.DATA_WIDTH(DATA_WIDTH)) u_alu (
      .ac       (ac),
      .link     (link),
      .operand  (alu_operand),
      .op       (alu_op),
      .op7      (op7_q),
      .new_ac   (alu_ac),
      .new_link (alu_link),
      .zero     (alu_zero)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         stall       <= 1'b1;
         pc          <= START_ADDR;
         ac          <= '0;
         link        <= 1'b0;
         halted      <= 1'b0;
         mem_rd_req  <= 1'b0;
         mem_wr_req  <= 1'b0;
         mem_addr    <= '0;
         mem_wr_data <= '0;
         rd_q        <= '0;
         skip        <= 1'b0;
         op7_sel     <= 1'b0;
         mem_q       <= '0;
         op7_q       <= '0;
      end else begin
         case (state)
            IDLE: begin
               stall <= 1'b0;
               if (accept) begin
                  stall <= 1'b1;
                  if (mem_any) begin
                     mem_q    <= pdp_mem_opcode;
                     op7_sel  <= 1'b0;
                     op7_q    <= '0;
                     mem_addr <= pdp_mem_opcode.mem_inst_addr;
                     if (pdp_mem_opcode.op_and || pdp_mem_opcode.op_tad || pdp_mem_opcode.op_isz) begin
                        state      <= RD;
                        mem_rd_req <= 1'b1;
                     end else if (pdp_mem_opcode.op_dca) begin
                        state       <= WR;
                        mem_wr_req  <= 1'b1;
                        mem_wr_data <= ac;
                     end else if (pdp_mem_opcode.op_jms) begin
                        state       <= WR;
                        mem_wr_req  <= 1'b1;
                        mem_wr_data <= DATA_WIDTH'(pc_inc);
                     end else begin
                        state <= DONE;
                     end
                  end else begin
                     mem_q   <= '0;
                     op7_sel <= 1'b1;
                     op7_q   <= '{cla: pdp_op7_opcode.cla, cll: pdp_op7_opcode.cll,
                                  cma: pdp_op7_opcode.cma, cml: pdp_op7_opcode.cml,
                                  iac: pdp_op7_opcode.iac};
                     if (pdp_op7_opcode.hlt) begin
                        state  <= HALT;
                        halted <= 1'b1;
                        pc     <= pc_inc;
                     end else begin
                        state <= DONE;
                     end
                  end
               end
            end
            RD: begin
               if (mem_ack) begin
                  mem_rd_req <= 1'b0;
                  rd_q       <= mem_rd_data;
                  if (mem_q.op_isz) begin
                     state       <= WR;
                     mem_wr_req  <= 1'b1;
                     mem_wr_data <= alu_ac;
                     skip        <= alu_zero;
                  end else begin
                     state <= DONE;
                  end
               end
            end
            WR: begin
               if (mem_ack) begin
                  mem_wr_req <= 1'b0;
                  state      <= DONE;
               end
            end
            DONE: begin
               state <= IDLE;
               stall <= 1'b0;
               if (mem_q.op_jmp) begin
                  pc <= mem_q.mem_inst_addr;
               end else if (mem_q.op_jms) begin
                  pc <= mem_q.mem_inst_addr + ADDR_WIDTH'(1);
               end else if (mem_q.op_isz && skip) begin
                  pc <= pc + ADDR_WIDTH'(2);
               end else begin
                  pc <= pc_inc;
               end
               if (mem_q.op_and || mem_q.op_tad || op7_sel) begin
                  ac   <= alu_ac;
                  link <= alu_link;
               end else if (mem_q.op_dca) begin
                  ac <= '0;
               end
            end
            HALT: state <= HALT;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_exec_memref_unit.sv
// Bench for exec_memref_unit: instruction vector table plus hand sequences for
// reset, reset during a write, and halt; memory writes are checked through a scoreboard.
module tb_exec_memref_unit;
   import pdp8_pkg::*;

   localparam logic [5:0] M_AND = 6'b100000;
   localparam logic [5:0] M_TAD = 6'b010000;
   localparam logic [5:0] M_ISZ = 6'b001000;
   localparam logic [5:0] M_DCA = 6'b000100;
   localparam logic [5:0] M_JMS = 6'b000010;
   localparam logic [5:0] M_JMP = 6'b000001;
   localparam logic [6:0] F_NOP = 7'b1000000;
   localparam logic [6:0] F_CLA = 7'b0100000;
   localparam logic [6:0] F_CLL = 7'b0010000;
   localparam logic [6:0] F_CMA = 7'b0001000;
   localparam logic [6:0] F_CML = 7'b0000100;
   localparam logic [6:0] F_IAC = 7'b0000010;
   localparam logic [6:0] F_HLT = 7'b0000001;

   typedef struct {
      logic [5:0]  m;
      logic [11:0] ea;
      logic [6:0]  f;
      int          wt;
      logic [11:0] ac;
      logic        l;
      logic [11:0] pc;
      int          lat;
      logic        wr;
      logic [11:0] wa;
      logic [11:0] wd;
   } vec_t;

   typedef struct packed {
      logic [11:0] a;
      logic [11:0] d;
   } wr_t;

   logic            clk = 1'b0;
   logic            reset;
   pdp_mem_opcode_s mop;
   pdp_op7_opcode_s op7;
   logic            stall;
   logic [11:0]     PC_value;
   logic            mem_rd_req;
   logic            mem_wr_req;
   logic [11:0]     mem_addr;
   logic [11:0]     mem_wr_data;
   logic [11:0]     mem_rd_data;
   logic            mem_ack;
   logic [11:0]     ac_out;
   logic            link_out;
   logic            halted;

   int   total = 0;
   int   bad = 0;
   int   ack_wait = 0;
   int   req_cycles = 0;
   logic resp_en = 1'b1;
   logic late_ack = 1'b0;
   logic [11:0] mem [0:4095];
   wr_t  exp_wr_q[$];
   vec_t vecs[17];

   always #5 clk = ~clk;

   exec_memref_unit #(.START_ADDR(12'o200)) dut (
      .clk            (clk),
      .reset          (reset),
      .pdp_mem_opcode (mop),
      .pdp_op7_opcode (op7),
      .stall          (stall),
      .PC_value       (PC_value),
      .mem_rd_req     (mem_rd_req),
      .mem_wr_req     (mem_wr_req),
      .mem_addr       (mem_addr),
      .mem_wr_data    (mem_wr_data),
      .mem_rd_data    (mem_rd_data),
      .mem_ack        (mem_ack),
      .ac_out         (ac_out),
      .link_out       (link_out),
      .halted         (halted)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0o required=%0o", name, act, exp);
      end
   endtask

   // Memory responder: acks after ack_wait idle cycles and pops the write scoreboard.
   initial begin
      mem_ack     = 1'b0;
      mem_rd_data = '0;
      forever begin
         int cnt;
         @(negedge clk);
         mem_ack = 1'b0;
         if (!resp_en) begin
            mem_ack = late_ack;
            cnt = 0;
         end else if (mem_rd_req || mem_wr_req) begin
            req_cycles++;
            if (mem_rd_req && mem_wr_req) check("req_exclusive", 32'(mem_wr_req), 32'd0);
            if (cnt >= ack_wait) begin
               cnt     = 0;
               mem_ack = 1'b1;
               if (mem_rd_req) begin
                  mem_rd_data = mem[mem_addr];
               end else begin
                  mem[mem_addr] = mem_wr_data;
                  if (exp_wr_q.size() == 0) begin
                     total++;
                     bad++;
                     $display("FAIL wr_unexpected actual=%0o:%0o required=none", mem_addr, mem_wr_data);
                  end else begin
                     wr_t e;
                     e = exp_wr_q.pop_front();
                     check("wr_addr", 32'(mem_addr), 32'(e.a));
                     check("wr_data", 32'(mem_wr_data), 32'(e.d));
                  end
               end
            end else begin
               cnt++;
            end
         end else begin
            cnt = 0;
         end
      end
   end

   task automatic issue(input logic [5:0] m, input logic [11:0] ea, input logic [6:0] f);
      int n = 0;
      while (stall && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (stall) check("ready_timeout", 32'(stall), 32'd0);
      mop = pdp_mem_opcode_s'({m, ea});
      op7 = pdp_op7_opcode_s'(f);
      @(negedge clk);
      mop = '0;
      op7 = '0;
   endtask

   task automatic run_vec(input vec_t v);
      int lat;
      ack_wait   = v.wt;
      req_cycles = 0;
      if (v.wr) exp_wr_q.push_back({v.wa, v.wd});
      issue(v.m, v.ea, v.f);
      lat = 1;
      while (stall && lat < 100) begin
         @(negedge clk);
         lat++;
      end
      check("latency", 32'(lat), 32'(v.lat));
      check("ac", 32'(ac_out), 32'(v.ac));
      check("link", 32'(link_out), 32'(v.l));
      check("pc", 32'(PC_value), 32'(v.pc));
      check("wr_drained", 32'(exp_wr_q.size()), 32'd0);
      if (v.m == M_JMP || v.m == 6'd0) check("no_mem_req", 32'(req_cycles), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int unsigned i = 0; i < 4096; i++) mem[i] = '0;
      mem[12'o300] = 12'o0001;
      mem[12'o301] = 12'o5252;
      mem[12'o310] = 12'o7777;
      mem[12'o311] = 12'o0005;
      mem[12'o320] = 12'o1234;

      //           m      ea       f                      wt ac       l     pc       lat wr    wa       wd
      vecs[0]  = '{6'd0,  12'o0,   F_CLA|F_CMA,           0, 12'o7777, 1'b0, 12'o0201, 2, 1'b0, 12'o0,   12'o0};
      vecs[1]  = '{M_TAD, 12'o300, 7'd0,                  2, 12'o0000, 1'b1, 12'o0202, 5, 1'b0, 12'o0,   12'o0};
      vecs[2]  = '{M_TAD, 12'o301, 7'd0,                  0, 12'o5252, 1'b1, 12'o0203, 3, 1'b0, 12'o0,   12'o0};
      vecs[3]  = '{M_AND, 12'o320, 7'd0,                  1, 12'o1210, 1'b1, 12'o0204, 4, 1'b0, 12'o0,   12'o0};
      vecs[4]  = '{M_ISZ, 12'o310, 7'd0,                  0, 12'o1210, 1'b1, 12'o0206, 4, 1'b1, 12'o310, 12'o0000};
      vecs[5]  = '{M_ISZ, 12'o311, 7'd0,                  1, 12'o1210, 1'b1, 12'o0207, 6, 1'b1, 12'o311, 12'o0006};
      vecs[6]  = '{M_DCA, 12'o330, 7'd0,                  0, 12'o0000, 1'b1, 12'o0210, 3, 1'b1, 12'o330, 12'o1210};
      vecs[7]  = '{6'd0,  12'o0,   F_CLA|F_CMA|F_IAC,     0, 12'o0000, 1'b0, 12'o0211, 2, 1'b0, 12'o0,   12'o0};
      vecs[8]  = '{6'd0,  12'o0,   F_CML|F_IAC,           0, 12'o0001, 1'b1, 12'o0212, 2, 1'b0, 12'o0,   12'o0};
      vecs[9]  = '{M_TAD, 12'o310, 7'd0,                  0, 12'o0001, 1'b1, 12'o0213, 3, 1'b0, 12'o0,   12'o0};
      vecs[10] = '{6'd0,  12'o0,   F_CLL|F_CMA,           0, 12'o7776, 1'b0, 12'o0214, 2, 1'b0, 12'o0,   12'o0};
      vecs[11] = '{M_JMS, 12'o400, 7'd0,                  1, 12'o7776, 1'b0, 12'o0401, 4, 1'b1, 12'o400, 12'o0215};
      vecs[12] = '{M_JMP, 12'o200, 7'd0,                  0, 12'o7776, 1'b0, 12'o0200, 2, 1'b0, 12'o0,   12'o0};
      vecs[13] = '{M_TAD, 12'o301, F_CLA,                 0, 12'o5250, 1'b1, 12'o0201, 3, 1'b0, 12'o0,   12'o0};
      vecs[14] = '{6'd0,  12'o0,   F_NOP,                 0, 12'o5250, 1'b1, 12'o0202, 2, 1'b0, 12'o0,   12'o0};
      vecs[15] = '{M_JMP, 12'o7777, 7'd0,                 0, 12'o5250, 1'b1, 12'o7777, 2, 1'b0, 12'o0,   12'o0};
      vecs[16] = '{6'd0,  12'o0,   F_NOP,                 0, 12'o5250, 1'b1, 12'o0000, 2, 1'b0, 12'o0,   12'o0};

      mop   = '0;
      op7   = '0;
      reset = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_stall", 32'(stall), 32'd1);
      check("rst_pc", 32'(PC_value), 32'o200);
      check("rst_ac", 32'(ac_out), 32'd0);
      check("rst_link", 32'(link_out), 32'd0);
      check("rst_halted", 32'(halted), 32'd0);
      check("rst_reqs", 32'({mem_rd_req, mem_wr_req}), 32'd0);
      check("rst_addr", 32'(mem_addr), 32'd0);
      check("rst_wdata", 32'(mem_wr_data), 32'd0);
      reset = 1'b0;
      @(negedge clk);
      check("rel_stall", 32'(stall), 32'd0);

      for (int i = 0; i < 17; i++) run_vec(vecs[i]);
      check("not_halted", 32'(halted), 32'd0);

      // Reset while a write is outstanding, then a stray ack.
      resp_en = 1'b0;
      issue(M_DCA, 12'o500, 7'd0);
      @(negedge clk);
      check("mid_wr_req", 32'(mem_wr_req), 32'd1);
      check("mid_addr", 32'(mem_addr), 32'o500);
      reset = 1'b1;
      @(negedge clk);
      check("midrst_wr_req", 32'(mem_wr_req), 32'd0);
      check("midrst_pc", 32'(PC_value), 32'o200);
      check("midrst_stall", 32'(stall), 32'd1);
      check("midrst_addr", 32'(mem_addr), 32'd0);
      reset = 1'b0;
      @(posedge clk);
      #1 late_ack = 1'b1;
      @(posedge clk);
      #1 late_ack = 1'b0;
      @(negedge clk);
      check("late_ack_stall", 32'(stall), 32'd0);
      check("late_ack_reqs", 32'({mem_rd_req, mem_wr_req}), 32'd0);
      check("late_ack_pc", 32'(PC_value), 32'o200);
      check("late_ack_ac", 32'(ac_out), 32'd0);
      resp_en = 1'b1;

      // op7 CLA+CMA+IAC from AC=0 toggles L, then halt.
      run_vec('{6'd0, 12'o0, F_CLA|F_CMA|F_IAC, 0, 12'o0000, 1'b1, 12'o0201, 2, 1'b0, 12'o0, 12'o0});
      req_cycles = 0;
      issue(6'd0, 12'o0, F_HLT);
      check("hlt_halted", 32'(halted), 32'd1);
      check("hlt_stall", 32'(stall), 32'd1);
      check("hlt_pc", 32'(PC_value), 32'o202);
      for (int i = 0; i < 20; i++) begin
         mop = pdp_mem_opcode_s'({6'($urandom_range(1, 63)), 12'($urandom)});
         op7 = pdp_op7_opcode_s'(7'($urandom_range(1, 127)));
         @(negedge clk);
         check("halt_stall_hold", 32'(stall), 32'd1);
      end
      mop = '0;
      op7 = '0;
      check("halt_pc_hold", 32'(PC_value), 32'o202);
      check("halt_ac_hold", 32'(ac_out), 32'd0);
      check("halt_no_req", 32'(req_cycles), 32'd0);
      check("halt_sticky", 32'(halted), 32'd1);
      reset = 1'b1;
      @(negedge clk);
      check("halt_reset", 32'(halted), 32'd0);
      reset = 1'b0;
      @(negedge clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/exec_memref_unit.md
Name: exec_memref_unit

Overview:
- Synthesisable PDP-8 execute stage, directly downstream of instr_decode.
- Consumes the decoder's pdp_mem_opcode / pdp_op7_opcode structs.
- Executes memory-reference instructions (AND, TAD, ISZ, DCA, JMS, JMP) and a basic op7 subset against a req/ack memory port.
- Owns AC, Link and PC; drives stall and PC_value back to the decoder.

Parameters:
START_ADDR, 12'o200, PC value loaded on reset
ADDR_WIDTH, `ADDR_WIDTH (12), address / PC width
DATA_WIDTH, `DATA_WIDTH (12), word / AC width

Ports:
clk  input  1  free-running clock; all logic on posedge
reset  input  1  synchronous, active-high reset
pdp_mem_opcode  input  pdp_mem_opcode_s  one-hot AND/TAD/ISZ/DCA/JMS/JMP plus resolved mem_inst_addr[11:0]
pdp_op7_opcode  input  pdp_op7_opcode_s  decoded op7 flags; subset used: CLA, CLL, CMA, CML, IAC, HLT, NOP
stall  output  1  1 = decoder must hold its current instruction
PC_value  output  ADDR_WIDTH  PC of next instruction to fetch
mem_rd_req  output  1  read request; held until ack
mem_wr_req  output  1  write request; held until ack
mem_addr  output  ADDR_WIDTH  read/write address
mem_wr_data  output  DATA_WIDTH  write data
mem_rd_data  input  DATA_WIDTH  read data; valid in the mem_ack cycle
mem_ack  input  1  one-cycle completion pulse for the active request
ac_out  output  DATA_WIDTH  accumulator (debug/observe)
link_out  output  1  link bit
halted  output  1  HLT executed; sticky until reset

Behaviour:
- Reset, synchronous and active-high, wins over everything, including mid-transaction:
  - state=IDLE, stall=1, PC_value=START_ADDR, AC=0, L=0, halted=0.
  - mem_rd_req=0, mem_wr_req=0, mem_addr=0, mem_wr_data=0.
  - Any pending ack is ignored.
- First cycle after reset deasserts: stall falls to 0. In IDLE, stall=0.
- Accept: in IDLE with stall=0 and any pdp_mem_opcode bit or any op7 flag set, the instruction is latched on that edge. stall=1 from the next cycle.
- Priority: mem opcode beats op7 if both are presented. No bits set means no accept; stay in IDLE.
- States and transitions:
  - IDLE
  - RD: mem_rd_req=1, mem_addr=EA
  - WR: mem_wr_req=1, mem_addr=EA, mem_wr_data set
  - DONE: one cycle; PC_value and AC/L updated; next state IDLE, stall=0
  - HALT
- Per instruction (all arithmetic mod 2^12, PC wraps 7777->0000):
  - AND: IDLE->RD->DONE. AC = AC & rd_data. PC+1.
  - TAD: IDLE->RD->DONE. {L,AC} = {L,AC} + {0,rd_data}; a carry out of bit 11 complements L. PC+1.
  - ISZ: IDLE->RD->WR->DONE. Write rd_data+1. PC+2 if the written value is 0, else PC+1.
  - DCA: IDLE->WR->DONE. Write AC, then AC=0. PC+1.
  - JMS: IDLE->WR->DONE. Write PC+1 to EA. PC = EA+1.
  - JMP: IDLE->DONE. PC = EA. No memory access.
  - op7: IDLE->DONE. Apply in order: CLA/CLL, then CMA/CML, then IAC (carry out complements L). PC+1.
  - op7 HLT: IDLE->HALT with PC+1. halted=1, stall=1 forever until reset.
- Minimum latency from accept to stall=0:
  - JMP/op7: 2 cycles.
  - AND/TAD/DCA/JMS: 3 cycles plus memory wait.
  - ISZ: 4 cycles plus memory wait.
- Memory handshake:
  - Request and address are stable until mem_ack. Request drops on the edge after ack.
  - At most one of rd_req/wr_req is high at a time.
  - mem_ack outside RD/WR is ignored.
- Opcode inputs are sampled only at accept; changes while stall=1 have no effect.

Decomposition:
- pdp8_pkg owns:
  - pdp_mem_opcode_s and pdp_op7_opcode_s (already shared with instr_decode)
  - `ADDR_WIDTH, `DATA_WIDTH
  - new exec_state_e enum {IDLE, RD, WR, DONE, HALT}
  - START_ADDR constant
- One natural sub-module, exec_alu: combinational. Inputs: AC, L, operand, op select. Outputs: new AC, new L, zero flag. Covers AND/TAD/increment/op7 group ops.
- The FSM and registers stay in exec_memref_unit.

Test Plan:
- Reset with stall/PC check: hold reset 3 cycles -> stall=1, PC_value=0200, AC=0. One cycle after release -> stall=0.
- TAD with carry: AC=7777, L=0, TAD to EA=0300 holding 0001, ack after 2 wait cycles -> AC=0000, L=1, PC_value=0201, stall low exactly 1 cycle after DONE.
- ISZ skip: mem[0310]=7777, ISZ 0310 -> write 0000 to 0310, PC advances by 2. Repeat with 0005 -> write 0006, PC advances by 1.
- JMS then JMP: PC=0200, JMS 0400 -> mem[0400]=0201, PC=0401. Then JMP 0200 -> PC=0200 with no mem_rd_req/mem_wr_req asserted.
- Reset mid-transaction: assert reset while in WR with no ack -> next cycle mem_wr_req=0, state IDLE, PC=0200. A late mem_ack is ignored.
- op7 and HLT: AC=0000, op7 CLA+CMA+IAC -> AC=0000, L toggled. HLT -> halted=1, stall stays 1 for 20 cycles despite new opcodes.
